// File: rtl/victim_cache_pkg.sv
// Shared types for the victim cache: LC-3b word/line/tag types, the victim entry
// record and the controller state encoding.
package victim_cache_pkg;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_cacheline;
  typedef logic [11:0]  lc3b_ctag;

  localparam int VC_ENTRIES = 4;

  typedef struct packed {
    logic          valid;
    logic          dirty;
    lc3b_ctag      tag;
    lc3b_cacheline data;
  } victim_entry_t;

  typedef enum logic [1:0] {
    VC_IDLE,
    VC_DRAIN,
    VC_FETCH
  } vc_state_e;

  function automatic lc3b_ctag line_tag(input lc3b_word addr);
    return addr[15:4];
  endfunction

endpackage

// File: rtl/victim_cache_if.sv
// L1-side and memory-side bus bundle of the victim cache; slave = cache, master = L1/memory.
interface victim_cache_if;
  import victim_cache_pkg::*;

  logic          eviction;
  logic          l1_read;
  logic          l1_write;
  lc3b_word      l1_address;
  lc3b_cacheline l1_wdata;
  lc3b_cacheline l1_rdata;
  logic          l1_resp;
  logic          pmem_read;
  logic          pmem_write;
  lc3b_word      pmem_address;
  lc3b_cacheline pmem_wdata;
  lc3b_cacheline pmem_rdata;
  logic          pmem_resp;

  modport slave (
    input  eviction, l1_read, l1_write, l1_address, l1_wdata, pmem_rdata, pmem_resp,
    output l1_rdata, l1_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport master (
    output eviction, l1_read, l1_write, l1_address, l1_wdata, pmem_rdata, pmem_resp,
    input  l1_rdata, l1_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/victim_cache_array.sv
// Fully-associative victim storage: parallel tag compare, hit / first-free lookup,
// round-robin replacement pointer, one write port and one invalidate port.
module victim_cache_array
  import victim_cache_pkg::*;
#(
  parameter  int ENTRIES = VC_ENTRIES,
  localparam int IW      = $clog2(ENTRIES)
) (
  input  logic          clk,
  input  logic          rst,
  input  lc3b_ctag      lookup_tag,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  victim_entry_t wr_entry,
  input  logic          inv_en,
  input  logic [IW-1:0] inv_idx,
  input  logic          rr_adv,
  output logic          hit,
  output logic [IW-1:0] hit_idx,
  output victim_entry_t hit_entry,
  output logic          free,
  output logic [IW-1:0] free_idx,
  output logic [IW-1:0] rr_idx,
  output victim_entry_t rr_entry
);

  victim_entry_t      entries_q [ENTRIES];
  victim_entry_t      entries_d [ENTRIES];
  logic [IW-1:0]      rr_q, rr_d;
  logic [ENTRIES-1:0] match;
  logic [ENTRIES-1:0] empty;

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_cmp
    assign match[gi] = entries_q[gi].valid && (entries_q[gi].tag == lookup_tag);
    assign empty[gi] = !entries_q[gi].valid;
  end

  // Scan downwards so the lowest matching / free index wins.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    free     = 1'b0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
      if (empty[i]) begin
        free     = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  assign hit_entry = entries_q[hit_idx];
  assign rr_idx    = rr_q;
  assign rr_entry  = entries_q[rr_q];

  always_comb begin
    entries_d = entries_q;
    if (inv_en) entries_d[inv_idx].valid = 1'b0;
    if (wr_en)  entries_d[wr_idx] = wr_entry;
    rr_d = rr_adv ? rr_q + IW'(1) : rr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) entries_q[i] <= '0;
      rr_q <= '0;
    end else begin
      entries_q <= entries_d;
      rr_q      <= rr_d;
    end
  end

endmodule

// File: rtl/victim_cache.sv
// Victim cache controller: IDLE/DRAIN/FETCH FSM plus one-line write-back buffer.
// Optional VICTIM_HIT_UNDER_DRAIN_EN lets read hits be answered while draining.
module victim_cache
  import victim_cache_pkg::*;
#(
  parameter int ENTRIES = VC_ENTRIES
) (
  input logic           clk,
  input logic           rst,
  victim_cache_if.slave bus
);

  localparam int IW = $clog2(ENTRIES);

  vc_state_e     state_q, state_d;
  logic          wb_valid_q, wb_valid_d;
  lc3b_cacheline wb_data_q, wb_data_d;
  logic          pmem_read_q, pmem_read_d;
  lc3b_word      pmem_address_q, pmem_address_d;

  logic          hit, free, wr_en, inv_en, rr_adv, hit_ok_state;
  logic [IW-1:0] hit_idx, free_idx, rr_idx, wr_idx;
  victim_entry_t hit_entry, rr_entry, wr_entry;
  logic          l1_resp_c;
  lc3b_cacheline l1_rdata_c;
  lc3b_ctag      req_tag;
  logic          unused_addr_bits;

  assign req_tag          = line_tag(bus.l1_address);
  assign unused_addr_bits = ^bus.l1_address[3:0];

`ifdef VICTIM_HIT_UNDER_DRAIN_EN
  assign hit_ok_state = (state_q == VC_IDLE) || (state_q == VC_DRAIN);
`else
  assign hit_ok_state = (state_q == VC_IDLE);
`endif

  victim_cache_array #(.ENTRIES(ENTRIES)) u_array (
    .clk       (clk),
    .rst       (rst),
    .lookup_tag(req_tag),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_entry  (wr_entry),
    .inv_en    (inv_en),
    .inv_idx   (hit_idx),
    .rr_adv    (rr_adv),
    .hit       (hit),
    .hit_idx   (hit_idx),
    .hit_entry (hit_entry),
    .free      (free),
    .free_idx  (free_idx),
    .rr_idx    (rr_idx),
    .rr_entry  (rr_entry)
  );

  always_comb begin
    state_d        = state_q;
    wb_valid_d     = wb_valid_q;
    wb_data_d      = wb_data_q;
    pmem_read_d    = pmem_read_q;
    pmem_address_d = pmem_address_q;
    wr_en          = 1'b0;
    wr_idx         = rr_idx;
    wr_entry       = '0;
    inv_en         = 1'b0;
    rr_adv         = 1'b0;
    l1_resp_c      = 1'b0;
    l1_rdata_c     = '0;

    // A dirty hit stays resident: L1 takes it clean, we keep write-back duty.
    if (hit_ok_state && bus.l1_read && !bus.eviction && hit) begin
      l1_resp_c  = 1'b1;
      l1_rdata_c = hit_entry.data;
      inv_en     = !hit_entry.dirty;
    end

    case (state_q)
      VC_IDLE: begin
        if (bus.eviction) begin
          wr_en     = 1'b1;
          wr_entry  = '{valid: 1'b1, dirty: bus.l1_write, tag: req_tag, data: bus.l1_wdata};
          l1_resp_c = bus.l1_write;
          if (hit) begin
            wr_idx         = hit_idx;
            wr_entry.dirty = hit_entry.dirty | bus.l1_write;
          end else if (free) begin
            wr_idx = free_idx;
          end else begin
            rr_adv = 1'b1;
            if (rr_entry.dirty) begin
              wb_valid_d     = 1'b1;
              wb_data_d      = rr_entry.data;
              pmem_address_d = {rr_entry.tag, 4'h0};
              state_d        = VC_DRAIN;
            end
          end
        end else if (bus.l1_read && !hit) begin
          pmem_read_d    = 1'b1;
          pmem_address_d = {req_tag, 4'h0};
          state_d        = VC_FETCH;
        end
      end
      VC_DRAIN: begin
        if (bus.pmem_resp) begin
          wb_valid_d     = 1'b0;
          wb_data_d      = '0;
          pmem_address_d = '0;
          state_d        = VC_IDLE;
        end
      end
      VC_FETCH: begin
        if (bus.pmem_resp) begin
          l1_resp_c      = 1'b1;
          l1_rdata_c     = bus.pmem_rdata;
          pmem_read_d    = 1'b0;
          pmem_address_d = '0;
          state_d        = VC_IDLE;
        end
      end
      default: state_d = VC_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= VC_IDLE;
      wb_valid_q     <= 1'b0;
      wb_data_q      <= '0;
      pmem_read_q    <= 1'b0;
      pmem_address_q <= '0;
    end else begin
      state_q        <= state_d;
      wb_valid_q     <= wb_valid_d;
      wb_data_q      <= wb_data_d;
      pmem_read_q    <= pmem_read_d;
      pmem_address_q <= pmem_address_d;
    end
  end

  // The buffer tag lives in pmem_address_q while draining.
  assign bus.l1_resp      = l1_resp_c;
  assign bus.l1_rdata     = l1_rdata_c;
  assign bus.pmem_read    = pmem_read_q;
  assign bus.pmem_write   = wb_valid_q;
  assign bus.pmem_address = pmem_address_q;
  assign bus.pmem_wdata   = wb_data_q;

endmodule

// File: doc/victim_cache.md
# victim_cache

Fully-associative victim cache between the L1 cache controller and physical memory (L2 side). Absorbs clean and dirty lines evicted by L1, returns them to L1 on a later miss without a memory access, and forwards true misses to memory. Dirty lines displaced from the victim array drain to memory through a one-line write-back buffer.

## Interface
- ENTRIES, 4, number of victim lines; power of two, ≥2
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- eviction  in  1  L1 is presenting an evicted line this cycle
- l1_read  in  1  L1 line fetch request
- l1_write  in  1  with eviction: evicted line is dirty
- l1_address  in  16 (lc3b_word)  line address; bits [3:0] ignored
- l1_wdata  in  128 (lc3b_cacheline)  evicted line data
- l1_rdata  out  128  returned line
- l1_resp  out  1  request complete
- pmem_read, pmem_write  out  1  memory strobes
- pmem_address  out  16  line address, bits [3:0] = 0
- pmem_wdata  out  128  write-back data
- pmem_rdata  in  128  memory read data
- pmem_resp  in  1  memory done

## Operation
- Entry: valid, dirty, tag (address[15:4]), 128-bit data. Write-back buffer: wb_valid, tag, data.
- States: IDLE, DRAIN, FETCH.
- Request decode in IDLE, priority: eviction > l1_read. eviction with l1_read both high: read ignored that cycle.
- Insertion (eviction=1), completes at the sampling edge:
  - target: entry with matching tag (update in place, dirty ← old dirty | l1_write); else lowest-index invalid entry; else entry at round-robin pointer rr, then rr ← rr+1 mod ENTRIES.
  - displaced valid dirty entry → write-back buffer, wb_valid=1, next state DRAIN. Displaced clean entry dropped.
  - l1_write=0 (clean): no l1_resp (L1 expects one-cycle completion).
  - l1_write=1 (dirty): l1_resp=1 combinationally in the same cycle.
- Read hit (l1_read, eviction=0, tag match): l1_rdata=entry data, l1_resp=1 same cycle. Clean entry invalidated at that edge; dirty entry stays valid (L1 installs it clean; victim keeps write-back responsibility).
- Read miss: next state FETCH. Line is not allocated in the victim.
- FETCH: pmem_read=1, pmem_address=l1_address line; on pmem_resp: l1_resp=1, l1_rdata=pmem_rdata same cycle, → IDLE.
- DRAIN: pmem_write=1, address/data from buffer; on pmem_resp: wb_valid←0, → IDLE. Requests stall in DRAIN (see Configuration). At most one buffered line: L1 always issues a read between evictions, and reads wait for drain.

## Timing
- Reset: all valid/dirty bits 0, wb_valid 0, rr 0, state IDLE; l1_resp, pmem_read, pmem_write 0; l1_rdata, pmem_address, pmem_wdata 0 when not driven.
- Reset mid-FETCH/DRAIN: strobes drop immediately (asynchronous); buffered dirty line is lost by design.
- Hit latency 0 cycles (combinational response); miss latency = memory latency, response in pmem_resp cycle.
- l1_* inputs must be held until l1_resp (reads, dirty evictions).
- pmem_* outputs stable from state entry until pmem_resp.

## Configuration
- VICTIM_HIT_UNDER_DRAIN_EN defined: read hits served in DRAIN exactly as in IDLE; read misses and evictions still wait for IDLE.
- Undefined: all requests stall in DRAIN until the buffer empties.

## Structure
- lc3b_types gains: lc3b_ctag (12-bit line tag), victim entry struct (valid, dirty, tag, data).
- Sub-module victim_cache_array: entry storage, parallel tag compare, hit index, first-invalid index, rr pointer; controller FSM and write-back buffer in victim_cache.

## Test plan
- Reset, read 0x1230: FETCH, pmem_address 0x1230; pmem_resp with D after 3 cycles → l1_resp same cycle, l1_rdata=D; victim stays empty.
- Clean eviction 0x2000 data A, then read 0x2000 → l1_resp same cycle, data A, no pmem strobe; repeat read 0x2000 → goes to pmem.
- Dirty eviction 0x3000 data B → l1_resp same cycle; read 0x3000 → hit B, entry retained; clean eviction 0x3000 data C → updated in place, still dirty, no new entry used.
- Dirty evictions 0x1000–0x4000, then clean eviction 0x5000 → entry 0 replaced, DRAIN writes 0x1000 with its data; read 0x6000 issued during drain → pmem_read only after drain pmem_resp.
- rst asserted two cycles into FETCH → pmem_read 0 immediately; subsequent read of a previously inserted line misses.
- With VICTIM_HIT_UNDER_DRAIN_EN: read hit during DRAIN answered same cycle; without it: answered first cycle after return to IDLE.
